ex_stage: RTL and testbench

Execute stage of the five-stage RV32IM pipeline. It sits between the ID/EX and EX/MEM pipeline registers and consumes `id_ex_reg`. It resolves operand forwarding, runs the RV32I ALU and the single-cycle RV32M multiplies, and resolves branches and jumps. It also contains a 32-iteration restoring divider for DIV/DIVU/REM/REMU. It produces `ex_mem_next` (type `ex_mem_reg_t`), which the memory stage registers.

---
 rtl/ex_stage.sv | 238 +++++++++++++++++++++++
 tb/tb_ex_stage.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage of the RV32IM pipeline: operand forwarding, ALU, single-cycle
// multiplies, branch/jump resolution and a 32-step restoring divider.
package ex_stage_pkg;

   typedef enum logic [4:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
      ALU_OR, ALU_AND, ALU_LUI, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
      ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
   } alu_op_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      alu_op_t     alu_op;
      logic        alu_src_imm;
      logic        alu_src_pc;
      logic        branch;
      logic        jump;
      logic        jalr;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic [1:0]  mem_width;
      logic        mem_unsigned;
      logic        mem_to_reg;
   } id_ex_reg_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] alu_result;
      logic [31:0] rs2_data;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic [1:0]  mem_width;
      logic        mem_unsigned;
      logic        mem_to_reg;
   } ex_mem_reg_t;

   typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

endpackage

module ex_stage
   import ex_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  id_ex_reg_t  id_ex_reg,
   input  logic        fwd_mem_en,
   input  logic [4:0]  fwd_mem_rd,
   input  logic [31:0] fwd_mem_data,
   input  logic        fwd_wb_en,
   input  logic [4:0]  fwd_wb_rd,
   input  logic [31:0] fwd_wb_data,
   output ex_mem_reg_t ex_mem_next,
   output logic        branch_taken,
   output logic [31:0] branch_target,
   output logic        stall_req
);

   function automatic logic [31:0] fwd_sel(input logic [4:0] rs, input logic [31:0] rf,
                                           input logic m_en, input logic [4:0] m_rd,
                                           input logic [31:0] m_data, input logic w_en,
                                           input logic [4:0] w_rd, input logic [31:0] w_data);
      if (m_en && m_rd == rs && rs != 5'd0)      return m_data;
      else if (w_en && w_rd == rs && rs != 5'd0) return w_data;
      else                                        return rf;
   endfunction

   logic [31:0] rs1_fwd, rs2_fwd, op_a, op_b, alu_res, div_result, abs_a, abs_b;
   logic [31:0] quot_fin, rem_fin;
   logic [4:0]  shamt;
   logic        mul_sign_a, mul_sign_b, br_cond;
   logic signed [63:0] prod;
   logic        is_div, div_signed, div_is_rem, div_zero, div_ovf, div_special, div_trigger;
   logic        div_done, div_special_done;
   logic [32:0] rem_shift, trial;

   div_state_t  div_state_q, div_state_d;
   logic [4:0]  cnt_q;
   logic [31:0] quot_q, rem_q, dvsr_q;
   logic        qneg_q, rneg_q;

   assign rs1_fwd = fwd_sel(id_ex_reg.rs1, id_ex_reg.rs1_data, fwd_mem_en, fwd_mem_rd,
                            fwd_mem_data, fwd_wb_en, fwd_wb_rd, fwd_wb_data);
   assign rs2_fwd = fwd_sel(id_ex_reg.rs2, id_ex_reg.rs2_data, fwd_mem_en, fwd_mem_rd,
                            fwd_mem_data, fwd_wb_en, fwd_wb_rd, fwd_wb_data);
   assign op_a    = id_ex_reg.alu_src_pc  ? id_ex_reg.pc  : rs1_fwd;
   assign op_b    = id_ex_reg.alu_src_imm ? id_ex_reg.imm : rs2_fwd;
   assign shamt   = op_b[4:0];

   // One 33x33 signed multiplier serves all four variants via the extension bit.
   assign mul_sign_a = (id_ex_reg.alu_op == ALU_MULH) || (id_ex_reg.alu_op == ALU_MULHSU);
   assign mul_sign_b = (id_ex_reg.alu_op == ALU_MULH);
   assign prod = 64'($signed({mul_sign_a & op_a[31], op_a})) *
                 64'($signed({mul_sign_b & op_b[31], op_b}));

   assign is_div      = id_ex_reg.alu_op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
   assign div_signed  = id_ex_reg.alu_op inside {ALU_DIV, ALU_REM};
   assign div_is_rem  = id_ex_reg.alu_op inside {ALU_REM, ALU_REMU};
   assign div_zero    = (op_b == 32'd0);
   assign div_ovf     = div_signed && op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF;
   assign div_special = div_zero || div_ovf;
   assign div_trigger = id_ex_reg.valid && !flush && is_div && div_state_q == DIV_IDLE;
   assign abs_a       = (div_signed && op_a[31]) ? -op_a : op_a;
   assign abs_b       = (div_signed && op_b[31]) ? -op_b : op_b;

   // A negative trial difference (bit 32 set) means the divisor did not fit.
   assign rem_shift = {rem_q, quot_q[31]};
   assign trial     = rem_shift - {1'b0, dvsr_q};
   assign quot_fin  = qneg_q ? -quot_q : quot_q;
   assign rem_fin   = rneg_q ? -rem_q  : rem_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) div_state_q <= DIV_IDLE;
      else     div_state_q <= div_state_d;
   end

   // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latch).
   always_comb begin
      div_state_d = div_state_q;
      case (div_state_q)
         DIV_IDLE: if (div_trigger && !div_special) div_state_d = DIV_BUSY;
         DIV_BUSY: if (flush) div_state_d = DIV_IDLE;
                   else if (cnt_q == 5'd31) div_state_d = DIV_DONE;
         DIV_DONE: if (flush || !stall) div_state_d = DIV_IDLE;
         default:  div_state_d = DIV_IDLE;
      endcase
   end

   always_comb begin
      div_done         = (div_state_q == DIV_DONE);
      div_special_done = (div_state_q == DIV_IDLE) && is_div && div_special;
      stall_req        = !rst && !flush &&
                         ((div_trigger && !div_special) || div_state_q == DIV_BUSY);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   // NOTE: the result registers are plain flops, so they are reset to a known zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= 5'd0;
         quot_q <= 32'd0;
         rem_q  <= 32'd0;
         dvsr_q <= 32'd0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
      end else if (div_state_q == DIV_IDLE && div_trigger && !div_special) begin
         cnt_q  <= 5'd0;
         quot_q <= abs_a;
         rem_q  <= 32'd0;
         dvsr_q <= abs_b;
         qneg_q <= div_signed && (op_a[31] ^ op_b[31]);
         rneg_q <= div_signed && op_a[31];
      end else if (div_state_q == DIV_BUSY) begin
         cnt_q  <= cnt_q + 5'd1;
         quot_q <= {quot_q[30:0], ~trial[32]};
         rem_q  <= trial[32] ? rem_shift[31:0] : trial[31:0];
      end
   end

   always_comb begin
      div_result = 32'd0;
      if (div_done)      div_result = div_is_rem ? rem_fin : quot_fin;
      else if (div_zero) div_result = div_is_rem ? op_a : 32'hFFFF_FFFF;
      else if (div_ovf)  div_result = div_is_rem ? 32'd0 : 32'h8000_0000;
   end

   always_comb begin
      alu_res = 32'd0;
      case (id_ex_reg.alu_op)
         ALU_ADD:    alu_res = op_a + op_b;
         ALU_SUB:    alu_res = op_a - op_b;
         ALU_SLL:    alu_res = op_a << shamt;
         ALU_SLT:    alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
         ALU_SLTU:   alu_res = {31'd0, op_a < op_b};
         ALU_XOR:    alu_res = op_a ^ op_b;
         ALU_SRL:    alu_res = op_a >> shamt;
         ALU_SRA:    alu_res = $signed(op_a) >>> shamt;
         ALU_OR:     alu_res = op_a | op_b;
         ALU_AND:    alu_res = op_a & op_b;
         ALU_LUI:    alu_res = op_b;
         ALU_MUL:    alu_res = prod[31:0];
         ALU_MULH, ALU_MULHSU, ALU_MULHU: alu_res = prod[63:32];
         ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: alu_res = div_result;
         default:    alu_res = 32'd0;
      endcase
      if (id_ex_reg.jump) alu_res = id_ex_reg.pc + 32'd4;
   end

   always_comb begin
      br_cond = 1'b0;
      case (id_ex_reg.alu_op)
         ALU_BEQ:  br_cond = (rs1_fwd == rs2_fwd);
         ALU_BNE:  br_cond = (rs1_fwd != rs2_fwd);
         ALU_BLT:  br_cond = ($signed(rs1_fwd) <  $signed(rs2_fwd));
         ALU_BGE:  br_cond = ($signed(rs1_fwd) >= $signed(rs2_fwd));
         ALU_BLTU: br_cond = (rs1_fwd <  rs2_fwd);
         ALU_BGEU: br_cond = (rs1_fwd >= rs2_fwd);
         default:  br_cond = 1'b0;
      endcase
   end

   assign branch_target = id_ex_reg.jalr ? ((rs1_fwd + id_ex_reg.imm) & ~32'd1)
                                         : (id_ex_reg.pc + id_ex_reg.imm);
   assign branch_taken  = !rst && id_ex_reg.valid && !flush &&
                          (id_ex_reg.jump || (id_ex_reg.branch && br_cond));

   always_comb begin
      ex_mem_next = '0;
      if (!rst && !flush && id_ex_reg.valid) begin
         ex_mem_next.valid        = is_div ? (div_done || div_special_done) : 1'b1;
         ex_mem_next.pc           = id_ex_reg.pc;
         ex_mem_next.alu_result   = alu_res;
         ex_mem_next.rs2_data     = rs2_fwd;
         ex_mem_next.rd           = id_ex_reg.rd;
         ex_mem_next.reg_write    = id_ex_reg.reg_write;
         ex_mem_next.mem_read     = id_ex_reg.mem_read;
         ex_mem_next.mem_write    = id_ex_reg.mem_write;
         ex_mem_next.mem_width    = id_ex_reg.mem_width;
         ex_mem_next.mem_unsigned = id_ex_reg.mem_unsigned;
         ex_mem_next.mem_to_reg   = id_ex_reg.mem_to_reg;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized ALU, branch,
// jump and divide traffic compared against an arithmetic reference model.
module tb_ex_stage;
   import ex_stage_pkg::*;

   logic        clk, rst, stall, flush;
   id_ex_reg_t  id_ex_reg;
   logic        fwd_mem_en, fwd_wb_en;
   logic [4:0]  fwd_mem_rd, fwd_wb_rd;
   logic [31:0] fwd_mem_data, fwd_wb_data;
   ex_mem_reg_t ex_mem_next;
   logic        branch_taken, stall_req;
   logic [31:0] branch_target;

   int checks = 0;
   int errors = 0;

   ex_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_ex_reg(id_ex_reg),
      .fwd_mem_en(fwd_mem_en), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
      .fwd_wb_en(fwd_wb_en), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
      .ex_mem_next(ex_mem_next), .branch_taken(branch_taken),
      .branch_target(branch_target), .stall_req(stall_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fwd_model(input logic [4:0] rs, input logic [31:0] rf);
      if (rs == 0) return rf;
      if (fwd_mem_en && fwd_mem_rd == rs) return fwd_mem_data;
      if (fwd_wb_en && fwd_wb_rd == rs) return fwd_wb_data;
      return rf;
   endfunction

   function automatic logic [31:0] alu_model(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      longint p;
      longint unsigned pu;
      sa = a;
      sb = b;
      case (op)
         ALU_ADD:    return a + b;
         ALU_SUB:    return a - b;
         ALU_SLL:    return a << b[4:0];
         ALU_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
         ALU_SLTU:   return (a < b) ? 32'd1 : 32'd0;
         ALU_XOR:    return a ^ b;
         ALU_SRL:    return a >> b[4:0];
         ALU_SRA:    return 32'(sa >>> b[4:0]);
         ALU_OR:     return a | b;
         ALU_AND:    return a & b;
         ALU_LUI:    return b;
         ALU_MUL:    begin p = longint'(sa) * longint'(sb); return p[31:0]; end
         ALU_MULH:   begin p = longint'(sa) * longint'(sb); return p[63:32]; end
         ALU_MULHSU: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
         ALU_MULHU:  begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
         ALU_DIV:    begin
                        if (b == 0) return 32'hFFFF_FFFF;
                        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                        return 32'(sa / sb);
                     end
         ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         ALU_REM:    begin
                        if (b == 0) return a;
                        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                        return 32'(sa % sb);
                     end
         ALU_REMU:   return (b == 0) ? a : a % b;
         default:    return 32'd0;
      endcase
   endfunction

   function automatic logic br_model(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      sa = a;
      sb = b;
      case (op)
         ALU_BEQ:  return a == b;
         ALU_BNE:  return a != b;
         ALU_BLT:  return sa < sb;
         ALU_BGE:  return sa >= sb;
         ALU_BLTU: return a < b;
         ALU_BGEU: return a >= b;
         default:  return 1'b0;
      endcase
   endfunction

   function automatic id_ex_reg_t mk(input alu_op_t op, input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                                     input logic src_imm, input logic src_pc);
      id_ex_reg_t t;
      t = '0;
      t.valid = 1'b1;  t.pc = 32'h100;  t.rs1 = rs1;  t.rs2 = rs2;
      t.rs1_data = d1; t.rs2_data = d2; t.imm = imm;  t.alu_op = op;
      t.alu_src_imm = src_imm; t.alu_src_pc = src_pc;
      t.rd = 5'd3;     t.reg_write = 1'b1;
      return t;
   endfunction

   // Runs one divide from an idle unit, measures the stall window and checks the result.
   task automatic do_div(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit retrig, input string tag);
      logic [31:0] exp;
      int n;
      bit spec;
      exp  = alu_model(op, a, b);
      spec = (b == 0) || ((op == ALU_DIV || op == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      @(posedge clk); #1;
      id_ex_reg = mk(op, 5'd1, 5'd2, a, b, 32'd0, 1'b0, 1'b0);
      #1;
      n = 0;
      while (stall_req === 1'b1 && n < 100) begin
         n++;
         @(posedge clk); #2;
      end
      check({tag, "_stall_cycles"}, 32'(n), spec ? 32'd0 : 32'd33);
      check({tag, "_valid"}, 32'(ex_mem_next.valid), 32'd1);
      check({tag, "_result"}, ex_mem_next.alu_result, exp);
      for (int i = 0; i < hold; i++) begin
         stall = 1'b1;
         @(posedge clk); #2;
         check({tag, "_hold_valid"}, 32'(ex_mem_next.valid), 32'd1);
         check({tag, "_hold_result"}, ex_mem_next.alu_result, exp);
      end
      stall = 1'b0;
      if (retrig && !spec) begin
         @(posedge clk); #2;
         check({tag, "_valid_once"}, 32'(ex_mem_next.valid), 32'd0);
         check({tag, "_retrigger"}, 32'(stall_req), 32'd1);
         flush = 1'b1;
         #1;
         check({tag, "_flush_idle_stall"}, 32'(stall_req), 32'd0);
         @(posedge clk); #1;
         flush = 1'b0;
      end else begin
         @(posedge clk); #1;
      end
      id_ex_reg = '0;
   endtask

   logic [31:0] a, b, r1, r2;
   id_ex_reg_t  ins;
   logic [31:0] exp_res;

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      fwd_mem_en = 1'b0; fwd_mem_rd = '0; fwd_mem_data = '0;
      fwd_wb_en  = 1'b0; fwd_wb_rd  = '0; fwd_wb_data  = '0;
      id_ex_reg = mk(ALU_ADD, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0);
      id_ex_reg.jump = 1'b1;
      #3;
      check("reset_stall_req", 32'(stall_req), 32'd0);
      check("reset_branch_taken", 32'(branch_taken), 32'd0);
      check("reset_ex_mem_zero", 32'(|ex_mem_next), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      id_ex_reg = '0;
      #1;
      check("idle_no_stall", 32'(stall_req), 32'd0);

      // Forwarding priority: MEM over WB, x0 never forwarded.
      @(posedge clk); #1;
      id_ex_reg = mk(ALU_ADD, 5'd1, 5'd2, 32'd1, 32'd7, 32'd0, 1'b0, 1'b0);
      fwd_mem_en = 1'b1; fwd_mem_rd = 5'd1; fwd_mem_data = 32'd5;
      fwd_wb_en  = 1'b1; fwd_wb_rd  = 5'd1; fwd_wb_data  = 32'd9;
      #1;
      check("fwd_mem_priority", ex_mem_next.alu_result, 32'd12);
      check("fwd_rs2_regfile", ex_mem_next.rs2_data, 32'd7);
      @(posedge clk); #1;
      id_ex_reg = mk(ALU_ADD, 5'd0, 5'd2, 32'h11, 32'd7, 32'd0, 1'b0, 1'b0);
      fwd_mem_rd = 5'd0; fwd_wb_rd = 5'd2; fwd_wb_data = 32'd100;
      #1;
      check("fwd_x0_uses_regfile", ex_mem_next.alu_result, 32'h75);
      check("fwd_wb_rs2_out", ex_mem_next.rs2_data, 32'd100);
      fwd_mem_en = 1'b0; fwd_wb_en = 1'b0;

      // Branch, JALR and flush of a jump.
      @(posedge clk); #1;
      id_ex_reg = mk(ALU_BEQ, 5'd1, 5'd2, 32'd4, 32'd4, 32'hFFFF_FFF8, 1'b0, 1'b0);
      id_ex_reg.branch = 1'b1;
      #1;
      check("beq_taken", 32'(branch_taken), 32'd1);
      check("beq_target", branch_target, 32'hF8);
      @(posedge clk); #1;
      id_ex_reg = mk(ALU_ADD, 5'd1, 5'd0, 32'h203, 32'd0, 32'd0, 1'b0, 1'b0);
      id_ex_reg.jump = 1'b1; id_ex_reg.jalr = 1'b1;
      #1;
      check("jalr_target", branch_target, 32'h202);
      check("jalr_link", ex_mem_next.alu_result, 32'h104);
      check("jalr_taken", 32'(branch_taken), 32'd1);
      flush = 1'b1;
      #1;
      check("flush_no_taken", 32'(branch_taken), 32'd0);
      check("flush_ex_mem_zero", 32'(|ex_mem_next), 32'd0);
      flush = 1'b0;

      // Multiply high variants.
      @(posedge clk); #1;
      id_ex_reg = mk(ALU_MULH, 5'd1, 5'd2, 32'hFFFF_FFFE, 32'd3, 32'd0, 1'b0, 1'b0);
      #1;
      check("mulh_neg", ex_mem_next.alu_result, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      id_ex_reg = mk(ALU_MULHU, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 1'b0);
      #1;
      check("mulhu", ex_mem_next.alu_result, 32'd1);

      // Divides: normal, held, special and back-to-back.
      do_div(ALU_DIV,  32'd100,        32'd7,          0, 1'b1, "div_100_7");
      do_div(ALU_REM,  32'hFFFF_FFF9,  32'd2,          4, 1'b0, "rem_m7_2_hold");
      do_div(ALU_DIVU, 32'h1234,       32'd0,          0, 1'b0, "divu_by0");
      do_div(ALU_REM,  32'h1234,       32'd0,          0, 1'b0, "rem_by0");
      do_div(ALU_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  0, 1'b0, "div_ovf");

      // Flush on BUSY cycle 10, then a fresh divide.
      @(posedge clk); #1;
      id_ex_reg = mk(ALU_DIV, 5'd1, 5'd2, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      flush = 1'b1;
      #1;
      check("busy_flush_stall", 32'(stall_req), 32'd0);
      check("busy_flush_valid", 32'(ex_mem_next.valid), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      id_ex_reg = '0;
      #1;
      check("busy_flush_to_idle", 32'(stall_req), 32'd0);
      do_div(ALU_DIV, 32'd9, 32'd3, 0, 1'b0, "div_9_3");

      // Reset in the middle of a divide.
      @(posedge clk); #1;
      id_ex_reg = mk(ALU_DIVU, 5'd1, 5'd2, 32'd5000, 32'd13, 32'd0, 1'b0, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rst_mid_div_stall", 32'(stall_req), 32'd0);
      check("rst_mid_div_zero", 32'(|ex_mem_next), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      id_ex_reg = '0;
      #1;
      check("rst_mid_div_idle", 32'(stall_req), 32'd0);

      // Randomized ALU / multiply traffic with random forwarding collisions.
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         ins = mk(alu_op_t'($urandom_range(0, 14)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         ins.pc = $urandom & 32'hFFFF_FFFC;
         ins.rd = 5'($urandom);
         ins.mem_write = 1'($urandom);
         fwd_mem_en = 1'($urandom); fwd_mem_rd = 5'($urandom_range(0, 3)); fwd_mem_data = $urandom;
         fwd_wb_en  = 1'($urandom); fwd_wb_rd  = 5'($urandom_range(0, 3)); fwd_wb_data  = $urandom;
         id_ex_reg = ins;
         #1;
         r1 = fwd_model(ins.rs1, ins.rs1_data);
         r2 = fwd_model(ins.rs2, ins.rs2_data);
         a  = ins.alu_src_pc  ? ins.pc  : r1;
         b  = ins.alu_src_imm ? ins.imm : r2;
         exp_res = alu_model(ins.alu_op, a, b);
         check($sformatf("rand_alu_%0d_%s", i, ins.alu_op.name()), ex_mem_next.alu_result, exp_res);
         check($sformatf("rand_alu_%0d_rs2", i), ex_mem_next.rs2_data, r2);
         check($sformatf("rand_alu_%0d_valid", i), 32'(ex_mem_next.valid), 32'd1);
         check($sformatf("rand_alu_%0d_rd", i), 32'(ex_mem_next.rd), 32'(ins.rd));
         check($sformatf("rand_alu_%0d_memw", i), 32'(ex_mem_next.mem_write), 32'(ins.mem_write));
      end
      fwd_mem_en = 1'b0; fwd_wb_en = 1'b0;

      // Randomized branches and jumps.
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         a = $urandom;
         case ($urandom_range(0, 2))
            0:       b = a;
            1:       b = a ^ 32'h8000_0000;
            default: b = $urandom;
         endcase
         ins = mk(alu_op_t'(int'(ALU_BEQ) + $urandom_range(0, 5)), 5'd1, 5'd2, a, b, $urandom, 1'b0, 1'b0);
         ins.pc = $urandom & 32'hFFFF_FFFC;
         ins.branch = 1'b1;
         id_ex_reg = ins;
         #1;
         check($sformatf("rand_br_%0d_%s", i, ins.alu_op.name()), 32'(branch_taken),
               32'(br_model(ins.alu_op, a, b)));
         check($sformatf("rand_br_%0d_target", i), branch_target, ins.pc + ins.imm);
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         ins = mk(ALU_ADD, 5'd1, 5'd2, $urandom, $urandom, $urandom, 1'b1, 1'b0);
         ins.pc = $urandom & 32'hFFFF_FFFC;
         ins.jump = 1'b1;
         ins.jalr = 1'($urandom);
         id_ex_reg = ins;
         #1;
         exp_res = ins.jalr ? ((ins.rs1_data + ins.imm) & 32'hFFFF_FFFE) : (ins.pc + ins.imm);
         check($sformatf("rand_jmp_%0d_target", i), branch_target, exp_res);
         check($sformatf("rand_jmp_%0d_link", i), ex_mem_next.alu_result, ins.pc + 32'd4);
         check($sformatf("rand_jmp_%0d_taken", i), 32'(branch_taken), 32'd1);
      end
      @(posedge clk); #1;
      id_ex_reg = '0;

      // Randomized divides, including signed operands and small divisors.
      for (int i = 0; i < 6; i++) begin
         a = $urandom;
         b = (i % 2 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
         if (i == 5) b = -b;
         do_div(alu_op_t'(int'(ALU_DIV) + $urandom_range(0, 3)), a, b, 0, 1'b0,
                $sformatf("rand_div_%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
